// File: rtl/wishbone_arbiter2.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant held for a whole
// cyc, combinational request/response muxing, and a per-strobe watchdog that ends a stalled strobe with err.
module wishbone_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int TIMEOUT    = 16,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [TAG_WIDTH-1:0]  m0_tag,
  input  logic [SEL_WIDTH-1:0]  m0_sel,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_mosi,
  output logic [DATA_WIDTH-1:0] m0_miso,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [TAG_WIDTH-1:0]  m1_tag,
  input  logic [SEL_WIDTH-1:0]  m1_sel,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_mosi,
  output logic [DATA_WIDTH-1:0] m1_miso,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s0_cyc,
  output logic                  s0_stb,
  output logic                  s0_we,
  output logic [TAG_WIDTH-1:0]  s0_tag,
  output logic [SEL_WIDTH-1:0]  s0_sel,
  output logic [ADDR_WIDTH-1:0] s0_adr,
  output logic [DATA_WIDTH-1:0] s0_mosi,
  input  logic [DATA_WIDTH-1:0] s0_miso,
  input  logic                  s0_ack,
  input  logic                  s0_err,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a master owns the bus from grant until it drops cyc; each strobe
  // (stb high) completes in the cycle ack or err is seen, and ack/err are only
  // routed while the forwarded s0_stb is high.

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wd_err_q, wd_err_d;

  logic own0, own1, own_cyc, own_stb, fwd_stb, wd_inc, resp_ack, resp_err;

  assign own0     = (state_q == ST_GNT0);
  assign own1     = (state_q == ST_GNT1);
  assign own_cyc  = (own0 & m0_cyc) | (own1 & m1_cyc);
  assign own_stb  = (own0 & m0_stb) | (own1 & m1_stb);
  assign fwd_stb  = own_stb & ~wd_err_q;
  assign resp_ack = s0_ack & fwd_stb;
  assign resp_err = (s0_err & fwd_stb) | wd_err_q;
  // A strobe only ages while the owner keeps the bus and the slave is silent.
  assign wd_inc   = (TIMEOUT > 0) && own_cyc && own_stb && !s0_ack && !s0_err && !wd_err_q;

  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    wdog_d   = '0;
    wd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc && (!m1_cyc || !prio_q)) begin
          state_d = ST_GNT0;
          prio_d  = 1'b1;
        end else if (m1_cyc) begin
          state_d = ST_GNT1;
          prio_d  = 1'b0;
        end
      end
      ST_GNT0: if (!m0_cyc) state_d = ST_IDLE;
      ST_GNT1: if (!m1_cyc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (wd_inc) begin
      if (wdog_q == WD_MAX) wd_err_d = 1'b1;
      else                  wdog_d   = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      wdog_q   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      wdog_q   <= wdog_d;
      wd_err_q <= wd_err_d;
    end
  end

  always_comb begin
    s0_cyc  = 1'b0;
    s0_stb  = fwd_stb;
    s0_we   = 1'b0;
    s0_tag  = '0;
    s0_sel  = '0;
    s0_adr  = '0;
    s0_mosi = '0;
    m0_ack  = own0 & resp_ack;
    m0_err  = own0 & resp_err;
    m0_miso = own0 ? s0_miso : '0;
    m1_ack  = own1 & resp_ack;
    m1_err  = own1 & resp_err;
    m1_miso = own1 ? s0_miso : '0;
    if (own0) begin
      s0_cyc  = m0_cyc;
      s0_we   = m0_we;
      s0_tag  = m0_tag;
      s0_sel  = m0_sel;
      s0_adr  = m0_adr;
      s0_mosi = m0_mosi;
    end else if (own1) begin
      s0_cyc  = m1_cyc;
      s0_we   = m1_we;
      s0_tag  = m1_tag;
      s0_sel  = m1_sel;
      s0_adr  = m1_adr;
      s0_mosi = m1_mosi;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Directed bench for wishbone_arbiter2 with TIMEOUT=4: reset, single transfer,
// contention ordering, no preemption, watchdog expiry, ack at the limit and mid-transfer reset.
module tb_wishbone_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int SW = DW / 8;
  localparam int OUT_W = 7 + TW + SW + AW + 3 * DW;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [TW-1:0] m0_tag, m1_tag, s0_tag;
  logic [SW-1:0] m0_sel, m1_sel, s0_sel;
  logic [AW-1:0] m0_adr, m1_adr, s0_adr;
  logic [DW-1:0] m0_mosi, m1_mosi, s0_mosi, m0_miso, m1_miso, s0_miso;
  logic m0_ack, m0_err, m1_ack, m1_err, s0_cyc, s0_stb, s0_we, s0_ack, s0_err;
  logic [1:0] dbg_state;
  logic [OUT_W-1:0] all_out;

  int total = 0;
  int bad = 0;

  assign all_out = {s0_cyc, s0_stb, s0_we, s0_tag, s0_sel, s0_adr, s0_mosi,
                    m0_ack, m0_err, m0_miso, m1_ack, m1_err, m1_miso};

  wishbone_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_tag(m0_tag), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_mosi(m0_mosi), .m0_miso(m0_miso), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_tag(m1_tag), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_mosi(m1_mosi), .m1_miso(m1_miso), .m1_ack(m1_ack), .m1_err(m1_err),
    .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_tag(s0_tag), .s0_sel(s0_sel),
    .s0_adr(s0_adr), .s0_mosi(s0_mosi), .s0_miso(s0_miso), .s0_ack(s0_ack), .s0_err(s0_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_tag = '0; m0_sel = '0; m0_adr = '0; m0_mosi = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_tag = '0; m1_sel = '0; m1_adr = '0; m1_mosi = '0;
    s0_miso = '0; s0_ack = 0; s0_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_rst = 0;
    repeat (3) tick();
    sys_rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    sys_rst = 0;
    repeat (3) tick();
    @(negedge sys_clk);
    total++; if (all_out !== '0 || dbg_state !== 2'd0) begin bad++;
      $display("FAIL reset_hold: out=%h state=%0d want 0/0", all_out, dbg_state); end
    tick();
    sys_rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      total++; if (all_out !== '0 || dbg_state !== 2'd0) begin bad++;
        $display("FAIL reset_idle[%0d]: out=%h state=%0d want 0/0", i, all_out, dbg_state); end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'hf; m0_tag = 3'd5;
    @(negedge sys_clk);
    total++; if (s0_cyc !== 1'b0) begin bad++;
      $display("FAIL single_latency: s0_cyc=%b want 0", s0_cyc); end
    tick();
    @(negedge sys_clk);
    total++; if ({s0_cyc, s0_stb, s0_we, s0_adr, s0_sel, s0_tag} !== {3'b110, 32'h100, 4'hf, 3'd5}) begin bad++;
      $display("FAIL single_req: cyc=%b stb=%b we=%b adr=%h sel=%h tag=%0d want 1 1 0 100 f 5",
               s0_cyc, s0_stb, s0_we, s0_adr, s0_sel, s0_tag); end
    total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL single_noack: m0_ack=%b want 0", m0_ack); end
    tick();
    s0_ack = 1; s0_miso = 32'hDEADBEEF;
    @(negedge sys_clk);
    total++; if ({m0_ack, m0_err, m0_miso} !== {2'b10, 32'hDEADBEEF}) begin bad++;
      $display("FAIL single_resp: ack=%b err=%b miso=%h want 1 0 deadbeef", m0_ack, m0_err, m0_miso); end
    total++; if ({m1_ack, m1_err, m1_miso} !== '0) begin bad++;
      $display("FAIL single_other: m1 ack=%b err=%b miso=%h want 0", m1_ack, m1_err, m1_miso); end
    tick();
    m0_cyc = 0; m0_stb = 0; s0_ack = 0; s0_miso = '0;
    @(negedge sys_clk);
    total++; if (s0_cyc !== 1'b0 || dbg_state !== 2'd1) begin bad++;
      $display("FAIL single_release: s0_cyc=%b state=%0d want 0/1", s0_cyc, dbg_state); end
    tick();
    @(negedge sys_clk);
    total++; if (dbg_state !== 2'd0) begin bad++;
      $display("FAIL single_idle: state=%0d want 0", dbg_state); end
  endtask

  task automatic test_contention();
    int exp_owner;
    do_reset();
    m0_stb = 1; m0_we = 0; m0_adr = 32'h200; m0_mosi = 32'h11111111;
    m1_stb = 1; m1_we = 1; m1_adr = 32'h300; m1_mosi = 32'hCAFEF00D;
    for (int g = 0; g < 4; g++) begin
      exp_owner = g % 2;
      m0_cyc = 1; m1_cyc = 1;
      @(negedge sys_clk);
      total++; if (s0_cyc !== 1'b0 || dbg_state !== 2'd0) begin bad++;
        $display("FAIL cont_idle[%0d]: s0_cyc=%b state=%0d want 0/0", g, s0_cyc, dbg_state); end
      tick();
      s0_ack = 1;
      @(negedge sys_clk);
      total++; if (dbg_state !== 2'(exp_owner + 1) || s0_we !== 1'(exp_owner) ||
                   s0_adr !== (exp_owner == 1 ? 32'h300 : 32'h200) ||
                   s0_mosi !== (exp_owner == 1 ? 32'hCAFEF00D : 32'h11111111)) begin bad++;
        $display("FAIL cont_grant[%0d]: state=%0d we=%b adr=%h mosi=%h want owner m%0d",
                 g, dbg_state, s0_we, s0_adr, s0_mosi, exp_owner); end
      total++; if ({m1_ack, m0_ack} !== (exp_owner == 1 ? 2'b10 : 2'b01)) begin bad++;
        $display("FAIL cont_ack[%0d]: m1_ack=%b m0_ack=%b want owner m%0d", g, m1_ack, m0_ack, exp_owner); end
      tick();
      s0_ack = 0;
      if (exp_owner == 1) m1_cyc = 0; else m0_cyc = 0;
      @(negedge sys_clk);
      total++; if (s0_cyc !== 1'b0) begin bad++;
        $display("FAIL cont_drop[%0d]: s0_cyc=%b want 0", g, s0_cyc); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_no_preempt();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
    @(negedge sys_clk);
    total++; if (dbg_state !== 2'd1 || s0_adr !== 32'h400) begin bad++;
      $display("FAIL np_grant: state=%0d adr=%h want 1/400", dbg_state, s0_adr); end
    tick();
    for (int i = 0; i < 4; i++) begin
      s0_ack = 1;
      @(negedge sys_clk);
      total++; if ({m0_ack, m1_ack, dbg_state} !== 4'b10_01) begin bad++;
        $display("FAIL np_ack[%0d]: m0_ack=%b m1_ack=%b state=%0d want 1 0 1", i, m0_ack, m1_ack, dbg_state); end
      tick();
      s0_ack = 0;
      @(negedge sys_clk);
      total++; if (s0_adr !== 32'h400 || m0_ack !== 1'b0) begin bad++;
        $display("FAIL np_hold[%0d]: adr=%h m0_ack=%b want 400 0", i, s0_adr, m0_ack); end
      tick();
    end
    m0_cyc = 0; m0_stb = 0;
    @(negedge sys_clk);
    total++; if (s0_cyc !== 1'b0 || dbg_state !== 2'd1) begin bad++;
      $display("FAIL np_release: s0_cyc=%b state=%0d want 0/1", s0_cyc, dbg_state); end
    tick();
    @(negedge sys_clk);
    total++; if (dbg_state !== 2'd0 || s0_cyc !== 1'b0) begin bad++;
      $display("FAIL np_gap: state=%0d s0_cyc=%b want 0/0", dbg_state, s0_cyc); end
    tick();
    @(negedge sys_clk);
    total++; if (dbg_state !== 2'd2 || s0_adr !== 32'h500 || s0_cyc !== 1'b1) begin bad++;
      $display("FAIL np_m1: state=%0d adr=%h cyc=%b want 2/500/1", dbg_state, s0_adr, s0_cyc); end
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      total++; if (s0_stb !== 1'b1 || m0_err !== 1'b0) begin bad++;
        $display("FAIL wd_wait[%0d]: s0_stb=%b m0_err=%b want 1 0", i, s0_stb, m0_err); end
      tick();
    end
    s0_ack = 1;
    @(negedge sys_clk);
    total++; if ({s0_cyc, s0_stb, m0_err, m0_ack} !== 4'b1010) begin bad++;
      $display("FAIL wd_expire: cyc=%b stb=%b err=%b ack=%b want 1 0 1 0", s0_cyc, s0_stb, m0_err, m0_ack); end
    tick();
    @(negedge sys_clk);
    total++; if ({s0_stb, m0_err, m0_ack} !== 3'b101) begin bad++;
      $display("FAIL wd_recover: stb=%b err=%b ack=%b want 1 0 1", s0_stb, m0_err, m0_ack); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_ack_limit();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h700;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      total++; if ({m0_ack, m0_err} !== 2'b00) begin bad++;
        $display("FAIL lim_wait[%0d]: ack=%b err=%b want 0 0", i, m0_ack, m0_err); end
      tick();
    end
    s0_ack = 1;
    @(negedge sys_clk);
    total++; if ({m0_ack, m0_err} !== 2'b10) begin bad++;
      $display("FAIL lim_ack: ack=%b err=%b want 1 0", m0_ack, m0_err); end
    tick();
    s0_ack = 0;
    @(negedge sys_clk);
    total++; if ({m0_err, s0_stb} !== 2'b01) begin bad++;
      $display("FAIL lim_noerr: err=%b stb=%b want 0 1", m0_err, s0_stb); end
    tick();
    sys_rst = 0; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h800;
    tick();
    sys_rst = 1;
    @(negedge sys_clk);
    total++; if (all_out !== '0 || dbg_state !== 2'd0) begin bad++;
      $display("FAIL rst_mid: out=%h state=%0d want 0/0", all_out, dbg_state); end
    tick();
    @(negedge sys_clk);
    total++; if (dbg_state !== 2'd1 || s0_adr !== 32'h700) begin bad++;
      $display("FAIL rst_prio: state=%0d adr=%h want 1/700", dbg_state, s0_adr); end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_no_preempt();
    test_watchdog();
    test_ack_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
